// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encodings and default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// ALU operand/result bundle. zf/sf exist only when ALU_CC_EN is defined.
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  // No valid/ready: every cycle's inputs are one operation and the result is
  // valid one rising edge later; the ALU never stalls.
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic [1:0]              control;
  logic signed [WIDTH-1:0] out;
  logic                    overflow;
`ifdef ALU_CC_EN
  logic                    zf;
  logic                    sf;

  modport master (output a, b, control, input out, overflow, zf, sf);
  modport slave  (input a, b, control, output out, overflow, zf, sf);
`else
  modport master (output a, b, control, input out, overflow);
  modport slave  (input a, b, control, output out, overflow);
`endif
endinterface

// File: rtl/alu_adder.sv
// WIDTH-bit combinational adder with carry-in; reports signed overflow only.
module alu_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  // Carry-out is dropped on purpose: the sum wraps modulo 2^WIDTH.
  assign sum = x + y + {{(WIDTH-1){1'b0}}, cin};
  assign ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Registered ADD/SUB/AND/XOR ALU with signed-overflow flag.
// Define ALU_CC_EN to add registered zero/sign flags.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] nxt_out;
  logic             nxt_ovf;
  logic [WIDTH-1:0] out_q;
  logic             ovf_q;

  // SUB reuses the adder as a + ~b + 1.
  assign is_sub = (bus.control == ALU_SUB);
  assign b_eff  = is_sub ? ~bus.b : bus.b;

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .x   (bus.a),
    .y   (b_eff),
    .cin (is_sub),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_comb begin
    nxt_out = '0;
    nxt_ovf = 1'b0;
    case (bus.control)
      ALU_ADD, ALU_SUB: begin
        nxt_out = sum;
        nxt_ovf = add_ovf;
      end
      ALU_AND: nxt_out = bus.a & bus.b;
      ALU_XOR: nxt_out = bus.a ^ bus.b;
      default: begin
        nxt_out = '0;
        nxt_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= nxt_out;
      ovf_q <= nxt_ovf;
    end
  end

  assign bus.out      = out_q;
  assign bus.overflow = ovf_q;

`ifdef ALU_CC_EN
  logic zf_q;
  logic sf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
    end else begin
      zf_q <= (nxt_out == '0);
      sf_q <= nxt_out[WIDTH-1];
    end
  end

  assign bus.zf = zf_q;
  assign bus.sf = sf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors push expected results, a monitor
// pops one per issued operation one edge later and compares.
module tb_alu;
  import alu_pkg::*;

  localparam int W  = 64;
  localparam int EW = W + 3;  // {zf, sf, overflow, out}

  localparam logic [EW-1:0] CMP_MASK =
`ifdef ALU_CC_EN
    {EW{1'b1}};
`else
    {2'b00, {(W+1){1'b1}}};
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int            n_cmp  = 0;
  int            n_bad  = 0;
  logic          issued = 1'b0;

  logic [W-1:0] maxp;
  logic [W-1:0] minn;
  logic [W-1:0] m1;

  function automatic logic [EW-1:0] pack(input logic [W-1:0] o, input logic ov);
    return {(o == '0), o[W-1], ov, o};
  endfunction

  function automatic logic [EW-1:0] snapshot();
`ifdef ALU_CC_EN
    return {bus.zf, bus.sf, bus.overflow, bus.out};
`else
    return {2'b00, bus.overflow, bus.out};
`endif
  endfunction

  task automatic check(input string name, input logic [EW-1:0] got,
                       input logic [EW-1:0] exp);
    n_cmp++;
    if ((got & CMP_MASK) !== (exp & CMP_MASK)) begin
      n_bad++;
      $display("FAIL %s: got {zf,sf,ov,out}=%h expected %h",
               name, got & CMP_MASK, exp & CMP_MASK);
    end
  endtask

  // driver: present one operation for one cycle and record its expected result
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] ctrl, input logic [W-1:0] exp_out,
                       input logic exp_ov);
    bus.a       = a;
    bus.b       = b;
    bus.control = ctrl;
    issued      = 1'b1;
    exp_q.push_back(pack(exp_out, exp_ov));
    @(negedge clk);
  endtask

  // monitor: an operation present at a rising edge is checked just after it
  initial begin
    logic due;
    forever begin
      @(posedge clk);
      due = issued && rst_n;
      #1;
      if (due) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_underflow: got result %h, expected none queued",
                   bus.out);
        end else begin
          check("result", snapshot(), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    maxp = {1'b0, {(W-1){1'b1}}};
    minn = {1'b1, {(W-1){1'b0}}};
    m1   = '1;

    bus.a       = {$urandom, $urandom};
    bus.b       = {$urandom, $urandom};
    bus.control = 2'($urandom_range(0, 3));

    // asynchronous reset, checked before any rising edge
    #1 rst_n = 1'b0;
    #2 check("reset_async", snapshot(), pack('0, 1'b0));
    repeat (2) @(negedge clk);
    check("reset_hold", snapshot(), pack('0, 1'b0));

    // release reset and issue back-to-back, first result due on next edge
    rst_n = 1'b1;
    issue(64'd11, 64'd4, ALU_ADD, 64'd15, 1'b0);
    issue(maxp, 64'hFFFF_FFFF_FFFF_FFFD, ALU_SUB, 64'h8000_0000_0000_0002, 1'b1);
    issue(64'd11, 64'd4, ALU_SUB, 64'd7, 1'b0);
    issue(64'd4, 64'd11, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    issue(64'd11, 64'd4, ALU_AND, 64'd0, 1'b0);
    issue(64'd11, 64'd4, ALU_XOR, 64'd15, 1'b0);
    issue(maxp, 64'd1, ALU_ADD, 64'h8000_0000_0000_0000, 1'b1);
    issue(m1, 64'd1, ALU_ADD, 64'd0, 1'b0);
    issue(minn, 64'd1, ALU_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    issue(64'd0, minn, ALU_SUB, 64'h8000_0000_0000_0000, 1'b1);
    issue(minn, minn, ALU_ADD, 64'd0, 1'b1);
    issue(minn, minn, ALU_XOR, 64'd0, 1'b0);
    issue(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, ALU_AND,
          64'hF000_F000_F000_F000, 1'b0);
    issue(m1, m1, ALU_SUB, 64'd0, 1'b0);
    issue(maxp, maxp, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    issue(m1, m1, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    issued = 1'b0;

    // reset mid-operation: pending op is discarded, output clears at once
    bus.a       = 64'd100;
    bus.b       = 64'd23;
    bus.control = ALU_ADD;
    #2 rst_n = 1'b0;
    #1 check("reset_mid_async", snapshot(), pack('0, 1'b0));
    @(posedge clk);
    #1 check("reset_discard", snapshot(), pack('0, 1'b0));

    @(negedge clk);
    rst_n = 1'b1;
    issue(64'd20, 64'd22, ALU_ADD, 64'd42, 1'b0);
    issued = 1'b0;

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
